// File: rtl/rbz_spi_sequencer.sv
// Wishbone-programmed SPI frame generator that drives either rbzero SPI port.
// Mode-0 frames of 1..64 bits, MSB first, with sticky DONE/ERR and an IRQ pulse.
module rbz_spi_sequencer #(
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        vec_sclk,
    output logic        vec_mosi,
    output logic        vec_ss_n,
    output logic        reg_sclk,
    output logic        reg_mosi,
    output logic        reg_ss_n,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  bit_q, bit_d;
    logic [63:0] data_q, data_d;
    logic [7:0]  div_q, div_d;
    logic        target_q, target_d;
    logic        irq_en_q, irq_en_d;
    logic [5:0]  len_q, len_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        vec_sclk_q, vec_sclk_d;
    logic        vec_mosi_q, vec_mosi_d;
    logic        vec_ss_n_q, vec_ss_n_d;
    logic        reg_sclk_q, reg_sclk_d;
    logic        reg_mosi_q, reg_mosi_d;
    logic        reg_ss_n_q, reg_ss_n_d;
    logic        busy_q, busy_d;
    logic        irq_q, irq_d;

    logic        access, wr_en, rd_en, active, fin, start_go;
    logic        sclk_n, mosi_n, ssn_n;
    logic [31:0] status;
    logic        unused_adr;

    assign access     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr_en      = access & wbs_we_i;
    assign rd_en      = access & ~wbs_we_i;
    assign active     = (state_q != S_IDLE);
    assign fin        = (state_q == S_GAP) && (cnt_q == 8'd0);
    assign unused_adr = ^wbs_adr_i[1:0];
    assign status     = {18'd0, len_q, 3'd0, irq_en_q, target_q,
                         err_q, done_q, active};

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    // Register file and bus side; every write during a frame only raises ERR.
    always_comb begin
        ack_d    = access;
        dat_d    = dat_q;
        data_d   = data_q;
        div_d    = div_q;
        target_d = target_q;
        irq_en_d = irq_en_q;
        len_d    = len_q;
        done_d   = done_q;
        err_d    = err_q;
        start_go = 1'b0;
        if (wr_en) begin
            if (active) begin
                err_d = 1'b1;
            end else begin
                unique case (wbs_adr_i[3:2])
                    2'd0: begin
                        if (wbs_sel_i[0]) begin
                            start_go = wbs_dat_i[0];
                            target_d = wbs_dat_i[1];
                            irq_en_d = wbs_dat_i[2];
                            if (wbs_dat_i[4]) begin
                                done_d = 1'b0;
                                err_d  = 1'b0;
                            end
                        end
                        if (wbs_sel_i[1]) begin
                            len_d = wbs_dat_i[13:8];
                        end
                    end
                    2'd1: data_d[63:32] = merge(data_q[63:32], wbs_dat_i,
                                                wbs_sel_i);
                    2'd2: data_d[31:0] = merge(data_q[31:0], wbs_dat_i,
                                               wbs_sel_i);
                    2'd3: begin
                        if (wbs_sel_i[0]) begin
                            div_d = wbs_dat_i[7:0];
                        end
                    end
                endcase
            end
        end
        if (rd_en) begin
            unique case (wbs_adr_i[3:2])
                2'd0: dat_d = status;
                2'd1: dat_d = data_q[63:32];
                2'd2: dat_d = data_q[31:0];
                2'd3: dat_d = {24'd0, div_q};
            endcase
        end
        if (fin) begin
            done_d = 1'b1;
        end
    end

    // Frame sequencer; outputs are derived from the next state and registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        if (state_q == S_IDLE) begin
            if (start_go) begin
                state_d = S_SETUP;
                cnt_d   = div_q;
                bit_d   = len_d;
            end
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = div_q;
            unique case (state_q)
                S_SETUP: state_d = S_HIGH;
                S_HIGH: begin
                    if (bit_q == 6'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_q - 6'd1;
                    end
                end
                S_LOW:   state_d = S_HIGH;
                S_HOLD:  state_d = S_GAP;
                default: state_d = S_IDLE;
            endcase
        end

        sclk_n = (state_d == S_HIGH);
        mosi_n = (state_d inside {S_SETUP, S_HIGH, S_LOW}) & data_q[bit_d];
        ssn_n  = !(state_d inside {S_SETUP, S_HIGH, S_LOW, S_HOLD});

        vec_sclk_d = sclk_n & ~target_d;
        vec_mosi_d = mosi_n & ~target_d;
        vec_ss_n_d = ssn_n | target_d;
        reg_sclk_d = sclk_n & target_d;
        reg_mosi_d = mosi_n & target_d;
        reg_ss_n_d = ssn_n | ~target_d;
        busy_d     = (state_d != S_IDLE);
        irq_d      = fin & irq_en_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 6'd0;
            data_q     <= 64'd0;
            div_q      <= DIV_RESET;
            target_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            len_q      <= 6'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            vec_sclk_q <= 1'b0;
            vec_mosi_q <= 1'b0;
            vec_ss_n_q <= 1'b1;
            reg_sclk_q <= 1'b0;
            reg_mosi_q <= 1'b0;
            reg_ss_n_q <= 1'b1;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            div_q      <= div_d;
            target_q   <= target_d;
            irq_en_q   <= irq_en_d;
            len_q      <= len_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            vec_sclk_q <= vec_sclk_d;
            vec_mosi_q <= vec_mosi_d;
            vec_ss_n_q <= vec_ss_n_d;
            reg_sclk_q <= reg_sclk_d;
            reg_mosi_q <= reg_mosi_d;
            reg_ss_n_q <= reg_ss_n_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign vec_sclk  = vec_sclk_q;
    assign vec_mosi  = vec_mosi_q;
    assign vec_ss_n  = vec_ss_n_q;
    assign reg_sclk  = reg_sclk_q;
    assign reg_mosi  = reg_mosi_q;
    assign reg_ss_n  = reg_ss_n_q;
    assign busy      = busy_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_rbz_spi_sequencer.sv
// Scoreboard bench for rbz_spi_sequencer: a register/timing model predicts
// frames, busy lengths, irq pulses and read data; monitors compare.
module tb_rbz_spi_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        w_cyc = 1'b0, w_stb = 1'b0, w_we = 1'b0;
    logic [3:0]  w_sel = 4'h0, w_adr = 4'h0;
    logic [31:0] w_dat = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        vec_sclk, vec_mosi, vec_ss_n;
    logic        reg_sclk, reg_mosi, reg_ss_n;
    logic        busy, irq;

    rbz_spi_sequencer #(.DIV_RESET(8'd3)) dut (
        .clk(clk), .reset(reset),
        .wbs_cyc_i(w_cyc), .wbs_stb_i(w_stb), .wbs_we_i(w_we),
        .wbs_sel_i(w_sel), .wbs_adr_i(w_adr), .wbs_dat_i(w_dat),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .vec_sclk(vec_sclk), .vec_mosi(vec_mosi), .vec_ss_n(vec_ss_n),
        .reg_sclk(reg_sclk), .reg_mosi(reg_mosi), .reg_ss_n(reg_ss_n),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    int unsigned ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          tgt;
        int          len;
        logic [63:0] bits;
        int          low;
    } frame_t;

    frame_t      fq[$];
    int          bq[$];
    logic [31:0] rq[$];
    int          irq_exp = 0;

    // Reference model state
    logic [63:0] m_data;
    logic [7:0]  m_div;
    logic        m_tgt, m_ien, m_done, m_err;
    logic [5:0]  m_len;
    int unsigned m_k, m_dur;
    bit          m_run;

    function automatic bit m_busy(input int unsigned now);
        return m_run && now >= m_k && now < m_k + m_dur;
    endfunction

    task automatic m_settle(input int unsigned now);
        if (m_run && now >= m_k + m_dur) begin
            m_done = 1'b1;
            m_run  = 1'b0;
        end
    endtask

    task automatic m_reset();
        m_data = 64'd0; m_div = 8'd3; m_tgt = 0; m_ien = 0;
        m_len = 6'd0; m_done = 0; m_err = 0; m_run = 0;
        fq.delete(); bq.delete(); rq.delete(); irq_exp = 0;
    endtask

    task automatic m_write(input int unsigned now, input logic [3:0] adr,
                           input logic [31:0] d, input logic [3:0] sel);
        int h, n;
        frame_t f;
        m_settle(now);
        if (m_busy(now)) begin
            m_err = 1'b1;
            return;
        end
        case (adr[3:2])
            2'd0: begin
                if (sel[0]) begin
                    m_tgt = d[1]; m_ien = d[2];
                    if (d[4]) begin m_done = 0; m_err = 0; end
                end
                if (sel[1]) m_len = d[13:8];
                if (sel[0] && d[0]) begin
                    h = int'(m_div) + 1;
                    n = int'(m_len) + 1;
                    m_k = now + 1;
                    m_dur = h * (2 * n + 2);
                    m_run = 1'b1;
                    f.tgt = m_tgt;
                    f.len = n;
                    f.bits = (n == 64) ? m_data
                                       : (m_data & ((64'd1 << n) - 64'd1));
                    f.low = h * (2 * n + 1);
                    fq.push_back(f);
                    bq.push_back(m_dur);
                    if (m_ien) irq_exp++;
                end
            end
            2'd1: for (int b = 0; b < 4; b++)
                      if (sel[b]) m_data[32 + b*8 +: 8] = d[b*8 +: 8];
            2'd2: for (int b = 0; b < 4; b++)
                      if (sel[b]) m_data[b*8 +: 8] = d[b*8 +: 8];
            default: if (sel[0]) m_div = d[7:0];
        endcase
    endtask

    task automatic wb_drive(input bit we, input logic [3:0] adr,
                            input logic [31:0] d, input logic [3:0] sel);
        int lat = 0;
        w_cyc = 1; w_stb = 1; w_we = we; w_adr = adr; w_dat = d; w_sel = sel;
        do begin
            @(posedge clk); #1; lat++;
        end while (!wbs_ack_o && lat < 8);
        chk("ack_latency", lat, 1);
        @(negedge clk);
        w_cyc = 0; w_stb = 0; w_we = 0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] d,
                      input logic [3:0] sel = 4'hF);
        @(negedge clk);
        m_write(ncyc, adr, d, sel);
        wb_drive(1'b1, adr, d, sel);
    endtask

    task automatic rd(input logic [3:0] adr);
        logic [31:0] e;
        @(negedge clk);
        m_settle(ncyc);
        case (adr[3:2])
            2'd0: e = {18'd0, m_len, 3'd0, m_ien, m_tgt, m_err, m_done,
                       m_busy(ncyc)};
            2'd1: e = m_data[63:32];
            2'd2: e = m_data[31:0];
            default: e = {24'd0, m_div};
        endcase
        rq.push_back(e);
        wb_drive(1'b0, adr, 32'h0, 4'hF);
    endtask

    task automatic wait_done();
        if (m_run)
            while (ncyc < m_k + m_dur + 3) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_vec_ss_n", vec_ss_n, 1);
        chk("rst_reg_ss_n", reg_ss_n, 1);
        chk("rst_sclk", {vec_sclk, reg_sclk, vec_mosi, reg_mosi}, 0);
        chk("rst_busy_irq", {busy, irq}, 0);
        chk("rst_ack", wbs_ack_o, 0);
        repeat (n) @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    // Read-data monitor
    always begin
        @(posedge clk); #1;
        if (!reset && wbs_ack_o && !w_we) begin
            if (rq.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", wbs_dat_o, rq.pop_front());
        end
    end

    // SPI / busy / irq monitor
    logic        p_sclk[2], p_mosi[2], p_ssn[2];
    logic        s_sclk[2], s_mosi[2], s_ssn[2];
    bit          inf[2];
    int          nb[2], lowc[2], viol[2];
    logic [63:0] acc[2];
    int          brun = 0;
    logic        p_busy = 0, p_irq = 0;

    always begin
        @(posedge clk); #1;
        s_sclk[0] = vec_sclk; s_mosi[0] = vec_mosi; s_ssn[0] = vec_ss_n;
        s_sclk[1] = reg_sclk; s_mosi[1] = reg_mosi; s_ssn[1] = reg_ss_n;
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                inf[p] = 0; viol[p] = 0;
            end
            brun = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (s_ssn[p]) begin
                    if (s_sclk[p] || s_mosi[p]) viol[p]++;
                    if (inf[p]) begin
                        frame_t f;
                        inf[p] = 0;
                        if (fq.size() == 0) chk("frame_unexpected", 1, 0);
                        else begin
                            f = fq.pop_front();
                            chk("frame_port", p, f.tgt);
                            chk("frame_nbits", nb[p], f.len);
                            chk("frame_bits", acc[p], f.bits);
                            chk("frame_ss_low", lowc[p], f.low);
                            chk("frame_mode0", viol[p], 0);
                        end
                        viol[p] = 0;
                    end
                end else begin
                    if (!inf[p]) begin
                        inf[p] = 1; nb[p] = 0; lowc[p] = 0; acc[p] = 0;
                    end
                    lowc[p]++;
                    if (s_sclk[p] && s_mosi[p] != p_mosi[p]) viol[p]++;
                    if (s_sclk[p] && !p_sclk[p]) begin
                        acc[p] = {acc[p][62:0], s_mosi[p]};
                        nb[p]++;
                    end
                    if (!s_ssn[1-p]) viol[p]++;
                end
            end
            if (busy) brun++;
            else if (brun > 0) begin
                if (bq.size() == 0) chk("busy_unexpected", 1, 0);
                else chk("busy_len", brun, bq.pop_front());
                brun = 0;
            end
            if (irq) begin
                chk("irq_at_end", {p_busy, busy, p_irq}, 3'b100);
                if (irq_exp == 0) chk("irq_unexpected", 1, 0);
                else irq_exp--;
            end
        end
        for (int p = 0; p < 2; p++) begin
            p_sclk[p] = s_sclk[p]; p_mosi[p] = s_mosi[p]; p_ssn[p] = s_ssn[p];
        end
        p_busy = busy; p_irq = irq;
    end

    initial begin
        m_reset();
        do_reset(3);
        rd(4'h0);
        rd(4'hC);
        rd(4'h8);

        // 8-bit 0xA5 on the vector port at full speed
        wr(4'h8, 32'hA5);
        wr(4'hC, 32'h0);
        wr(4'h0, 32'h0000_0701);
        wait_done();
        rd(4'h0);

        // 64-bit frame on the register port with irq
        wr(4'h4, 32'hDEADBEEF);
        wr(4'h8, 32'h01234567);
        wr(4'hC, 32'h3);
        wr(4'h0, 32'h0000_3F07);
        wait_done();
        rd(4'h0);

        // Accesses while busy are acked but ignored and flag ERR
        wr(4'hC, 32'h1);
        wr(4'h8, 32'h1234);
        wr(4'h0, 32'h0000_0F01);
        wr(4'h0, 32'h0000_0203);
        wr(4'h8, 32'hFFFF);
        wait_done();
        rd(4'h0);
        rd(4'h8);
        wr(4'h0, 32'h0000_0F10);
        rd(4'h0);

        // Reset partway through a 16-bit frame, then a clean frame
        wr(4'hC, 32'h0);
        wr(4'h8, 32'hBEEF);
        wr(4'h0, 32'h0000_0F05);
        while (ncyc < m_k + 11) @(negedge clk);
        do_reset(1);
        rd(4'h0);
        wr(4'hC, 32'h0);
        wr(4'h8, 32'h0ABC);
        wr(4'h0, 32'h0000_0B01);
        wait_done();
        rd(4'h0);

        // Single-bit frame, then clear DONE/ERR
        wr(4'h8, 32'h1);
        wr(4'h0, 32'h0000_0001);
        wr(4'h8, 32'h0);
        wait_done();
        rd(4'h0);
        wr(4'h0, 32'h0000_0010);
        rd(4'h0);

        // Randomised frames
        for (int it = 0; it < 25; it++) begin
            logic [3:0] sel;
            logic [31:0] ctrl;
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'hF;
            wr(4'h4, $urandom, sel);
            wr(4'h8, $urandom, 4'hF);
            wr(4'hC, 32'($urandom_range(0, 3)));
            ctrl = {18'd0, 6'($urandom_range(0, 63)), 3'd0,
                    1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)),
                    1'b1};
            wr(4'h0, ctrl);
            if ($urandom_range(0, 2) == 0) wr(4'h8, $urandom);
            wait_done();
            rd(4'h0);
            if ($urandom_range(0, 1) == 0) wr(4'h0, 32'h0000_0010, 4'h1);
            rd(4'h4);
        end

        repeat (10) @(negedge clk);
        chk("frames_left", fq.size(), 0);
        chk("busy_left", bq.size(), 0);
        chk("irq_left", irq_exp, 0);
        chk("reads_left", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
